// File: rtl/spi_sipo_rx.sv
// spi_sipo_rx: serial-in/parallel-out SPI receive shift register with valid/ack handoff
module spi_sipo_rx #(
  parameter int WIDTH = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       ena,
  input  logic                       clr,
  input  logic                       DatIn,
  input  logic                       ack,
  output logic [WIDTH-1:0]           DatOut,
  output logic                       valid,
  output logic                       busy,
  output logic                       overrun,
  output logic [$clog2(WIDTH+1)-1:0] BitCnt
);
  localparam int CW = $clog2(WIDTH+1);
  logic [WIDTH-1:0] sr, sr_nxt;
  logic done;
  assign sr_nxt = MSB_FIRST ? {sr[WIDTH-2:0], DatIn} : {DatIn, sr[WIDTH-1:1]};
  assign done = ena && !clr && BitCnt == CW'(WIDTH-1);
  assign busy = |BitCnt;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      sr      <= '0;
      BitCnt  <= '0;
      DatOut  <= '0;
      valid   <= 1'b0;
      overrun <= 1'b0;
    end else begin
      if (clr) begin
        sr      <= '0;
        BitCnt  <= '0;
        overrun <= 1'b0;
      end else if (ena) begin
        sr     <= sr_nxt;
        BitCnt <= done ? '0 : BitCnt + 1'b1;
      end
      // a completion while the previous word is still pending is dropped, not queued
      if (done && (!valid || ack)) begin
        DatOut <= sr_nxt;
        valid  <= 1'b1;
      end else if (done) overrun <= 1'b1;
      else if (ack) valid <= 1'b0;
    end
endmodule

// File: tb/tb_spi_sipo_rx.sv
// tb_spi_sipo_rx: directed + random check of both bit orders against a queue-based word model
module tb_spi_sipo_rx;
  logic clk = 1'b0, rst = 1'b1, ena = 1'b0, clr = 1'b0, din = 1'b0, ack = 1'b0;
  logic [7:0] dm, dl;
  logic vm, vl, bm, bl, om, ol;
  logic [3:0] cm, cl;
  int checks = 0, errors = 0;
  bit q[$];
  logic m_vld = 1'b0, m_ovr = 1'b0;
  logic [7:0] m_dm = 8'h00, m_dl = 8'h00;

  always #5 clk = ~clk;

  spi_sipo_rx #(.WIDTH(8), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .rst(rst), .ena(ena), .clr(clr), .DatIn(din), .ack(ack),
    .DatOut(dm), .valid(vm), .busy(bm), .overrun(om), .BitCnt(cm));
  spi_sipo_rx #(.WIDTH(8), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .rst(rst), .ena(ena), .clr(clr), .DatIn(din), .ack(ack),
    .DatOut(dl), .valid(vl), .busy(bl), .overrun(ol), .BitCnt(cl));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("msb_dat", 32'(dm), 32'(m_dm));
    chk("lsb_dat", 32'(dl), 32'(m_dl));
    chk("msb_valid", 32'(vm), 32'(m_vld));
    chk("lsb_valid", 32'(vl), 32'(m_vld));
    chk("msb_ovr", 32'(om), 32'(m_ovr));
    chk("lsb_ovr", 32'(ol), 32'(m_ovr));
    chk("msb_cnt", 32'(cm), 32'(q.size()));
    chk("lsb_cnt", 32'(cl), 32'(q.size()));
    chk("msb_busy", 32'(bm), 32'(q.size() != 0));
    chk("lsb_busy", 32'(bl), 32'(q.size() != 0));
  endtask

  task automatic model_reset();
    q.delete();
    m_vld = 1'b0;
    m_ovr = 1'b0;
    m_dm = 8'h00;
    m_dl = 8'h00;
  endtask

  // one clock: drive, advance the model on the edge, check 1 time unit later
  task automatic step(input logic e, input logic d, input logic c, input logic a);
    logic [7:0] wm, wl;
    bit done;
    ena = e; din = d; clr = c; ack = a;
    @(posedge clk);
    done = 1'b0;
    if (c) begin
      q.delete();
      m_ovr = 1'b0;
    end else if (e) begin
      q.push_back(d);
      if (q.size() == 8) begin
        done = 1'b1;
        wm = 8'h00;
        wl = 8'h00;
        for (int i = 0; i < 8; i++) begin
          wm = wm + (8'(q[i]) << (7 - i));
          wl = wl + (8'(q[i]) << i);
        end
        q.delete();
        if (!m_vld || a) begin
          m_dm = wm;
          m_dl = wl;
          m_vld = 1'b1;
        end else m_ovr = 1'b1;
      end
    end
    if (!done && a) m_vld = 1'b0;
    #1;
    check_all();
  endtask

  task automatic send_word(input logic [7:0] w, input logic ack_last);
    for (int i = 0; i < 8; i++) step(1'b1, w[7-i], 1'b0, i == 7 ? ack_last : 1'b0);
  endtask

  initial begin
    #2 rst = 1'b0;
    #1 check_all();
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    step(1'b0, 1'b0, 1'b0, 1'b0);
    send_word(8'hB9, 1'b0);
    chk("b9_msb", 32'(dm), 32'h B9);
    chk("b9_lsb", 32'(dl), 32'h 9D);
    send_word(8'h3C, 1'b0);
    chk("ovr_set", 32'(om), 32'h1);
    chk("ovr_hold", 32'(dm), 32'h B9);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    chk("clr_ovr", 32'(om), 32'h0);
    chk("clr_dat", 32'(dm), 32'h B9);
    send_word(8'h3C, 1'b1);
    chk("ack_cmp_dat", 32'(dm), 32'h3C);
    chk("ack_cmp_vld", 32'(vm), 32'h1);
    chk("ack_cmp_ovr", 32'(om), 32'h0);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    chk("ack_drop", 32'(vm), 32'h0);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b0);
    chk("clr_cnt", 32'(cm), 32'h0);
    chk("clr_busy", 32'(bm), 32'h0);
    send_word(8'hA5, 1'b0);
    chk("a5_msb", 32'(dm), 32'h A5);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0, 1'b0);
    #2 rst = 1'b0;
    #1 model_reset();
    check_all();
    @(negedge clk) rst = 1'b1;
    send_word(8'hFF, 1'b0);
    chk("ff_msb", 32'(dm), 32'h FF);
    chk("ff_vld", 32'(vm), 32'h1);
    for (int i = 0; i < 400; i++)
      step($urandom_range(3) != 0, 1'($urandom), $urandom_range(31) == 0, $urandom_range(5) == 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/spi_sipo_rx.md
Name: spi_sipo_rx

Overview:
Serial-in/parallel-out receive shift register for the SPI controller; the receive-side counterpart of the transmit PISO shift register. It samples one bit of DatIn per ena strobe, assembles WIDTH-bit words, and presents each completed word on DatOut with a valid/ack handshake. It sits between the SPI bit-timing logic, which generates ena, and the host-side register or consumer.

Parameters:
WIDTH, 8, word length in bits (2..32)
MSB_FIRST, 1, 1 = first received bit lands in DatOut[WIDTH-1] (shift left); 0 = first bit lands in DatOut[0] (shift right)

Ports:
clk  in  1  system clock; all state changes on the rising edge
rst  in  1  reset, asynchronous, active-low
ena  in  1  bit strobe; DatIn is sampled on the rising edge where ena=1
clr  in  1  synchronous frame abort/restart
DatIn  in  1  serial data in
ack  in  1  consumer has taken DatOut
DatOut  out  WIDTH  last completed word
valid  out  1  DatOut holds an unacknowledged word
busy  out  1  partial word in progress (BitCnt != 0)
overrun  out  1  sticky flag: a word completed while the previous word was still unacknowledged
BitCnt  out  clog2(WIDTH+1)  number of bits received in the current word

Behaviour:
- Reset (rst=0, asynchronous): shift register, BitCnt, DatOut, valid, busy and overrun all go to 0 immediately and stay there while rst=0.
- FSM: IDLE (BitCnt=0), SHIFT (0<BitCnt<WIDTH). HOLD is tracked by the independent valid flag, not by an FSM state. Reception continues while valid=1.
- On each edge with ena=1 and clr=0:
  - Shift: MSB_FIRST=1 gives sr <= {sr[WIDTH-2:0], DatIn}; otherwise sr <= {DatIn, sr[WIDTH-1:1]}.
  - Increment BitCnt.
- Completion is the edge with ena=1 where BitCnt=WIDTH-1. On that edge:
  - The assembled word including the current DatIn bit is the completed word.
  - BitCnt returns to 0 (wrap); the shift register is not cleared, because the next word overwrites it.
  - If valid=0 or ack=1 on that edge: DatOut <= word and valid <= 1. The word and flag are visible the cycle after the final bit is sampled, so latency is 1 clk from the last ena.
  - If valid=1 and ack=0: DatOut is unchanged, the new word is discarded, and overrun <= 1.
- ack=1 with valid=1 and no completion on that edge: valid <= 0. ack while valid=0 is ignored.
- ack on the same edge as a completion: the new word is loaded, valid stays 1, and no overrun is flagged.
- clr=1: BitCnt <= 0, shift register <= 0, overrun <= 0. A simultaneous ena bit is discarded because clr wins. DatOut and valid are unaffected, and ack is still honoured on the same edge.
- ena=0: all state holds, apart from ack handling.
- busy = (BitCnt != 0), combinational from the registered BitCnt.
- Removing reset mid-word: after release, reception starts from an empty word and no partial data survives.

Test Plan:
- MSB_FIRST=1, WIDTH=8: reset, then 8 ena strobes with DatIn = 1,0,1,1,1,0,0,1. Required: DatOut=8'hB9 and valid=1 exactly one clk after the 8th strobe. BitCnt steps 0..7 then returns to 0; busy=1 during strobes 1..7.
- MSB_FIRST=0: same bit stream. Required: DatOut=8'h9D.
- Back-to-back words 8'hB9 then 8'h3C with ack never asserted. Required: DatOut stays 8'hB9, valid=1, and overrun=1 after the 16th strobe. A following clr clears overrun and leaves DatOut at 8'hB9.
- ack on the same edge as the 8th strobe of a second word 8'h3C. Required: DatOut=8'h3C, valid stays 1, overrun=0.
- clr asserted after 4 strobes, with one of them coinciding with an ena. Required: BitCnt=0 and busy=0. A fresh 8-bit 8'hA5 is then received correctly.
- rst pulled low after 5 strobes, asynchronously and between edges. Required: all outputs are 0 before the next clk edge. After release, 8 strobes of 8'hFF give DatOut=8'hFF and valid=1.
